calc2_port_issuer: RTL and testbench

- Upstream request issuer for one calc2_top port; four instances feed req1..req4.
- Accepts whole operations (cmd, op1, op2) over valid/ready and allocates a free tag from a 4-tag pool.
- Serialises each operation onto the calc2 two-cycle request protocol.
- Collects out_resp/out_data/out_tag into an in-order completion queue with backpressure.

---
 rtl/calc2_pkg.sv | 44 ++++
 rtl/calc2_cpl_fifo.sv | 50 +++++
 rtl/calc2_port_issuer.sv | 200 ++++++++++++++++++++
 tb/tb_calc2_port_issuer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// Shared types and widths for the calc2 port issuer and its completion FIFO.
package calc2_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int TAG_W  = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE    = 2'd0,
        RESP_OK      = 2'd1,
        RESP_OVF     = 2'd2,
        RESP_INVALID = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP1,
        S_OP2
    } issue_state_e;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [CMD_W-1:0]  cmd;
    } cpl_t;

    function automatic logic [TAG_W:0] count_ones(input logic [2**TAG_W-1:0] v);
        logic [TAG_W:0] n;
        n = '0;
        for (int i = 0; i < 2**TAG_W; i++)
            n = n + {{TAG_W{1'b0}}, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/calc2_cpl_fifo.sv
// In-order completion queue; storage is registered and the head reads as zero when empty.
module calc2_cpl_fifo import calc2_pkg::*; #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cpl_t push_data,
    input  logic pop,
    output logic valid,
    output cpl_t head
);

    localparam int DEPTH = 2**DEPTH_LOG2;

    cpl_t                  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Overflow is impossible: every entry holds a distinct allocated tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc2_port_issuer.sv
// Tagged request issuer for one calc2 port: two-cycle request serialiser plus in-order completion queue.
// Optional watchdog per tag is enabled with `define CALC2_ISSUE_TIMEOUT_EN.
module calc2_port_issuer import calc2_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int TAG_W  = 2
`ifdef CALC2_ISSUE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    output logic [TAG_W-1:0]  req_tag_out,
    input  logic [1:0]        rsp_resp,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic [TAG_W-1:0]  rsp_tag,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [1:0]        cpl_resp,
    output logic [DATA_W-1:0] cpl_data,
    output logic [TAG_W-1:0]  cpl_tag,
    output logic [CMD_W-1:0]  cpl_cmd,
    output logic [TAG_W:0]    outstanding,
    output logic              spurious_err
);

    localparam int NTAGS = 2**TAG_W;

    issue_state_e      state, state_next;
    logic [NTAGS-1:0]  alloc, responded;
    logic [CMD_W-1:0]  cmd_mem [NTAGS];
    logic [DATA_W-1:0] op2_q;
    logic [TAG_W-1:0]  cur_tag;
    logic [CMD_W-1:0]  req_cmd_next;
    logic [DATA_W-1:0] req_data_next;
    logic [TAG_W-1:0]  req_tag_next;
    logic              have_free;
    logic [TAG_W-1:0]  free_tag;
    logic              accept, pop, rsp_hit, rsp_spur, push, fifo_valid;
    cpl_t              push_data, head;

    always_comb begin
        have_free = 1'b0;
        free_tag  = '0;
        for (int i = NTAGS-1; i >= 0; i--) begin
            if (!alloc[i]) begin
                have_free = 1'b1;
                free_tag  = TAG_W'(i);
            end
        end
    end

    assign in_ready = !reset && (state == S_IDLE || state == S_OP2) && have_free;
    assign accept   = in_valid && in_ready;
    assign pop      = fifo_valid && cpl_ready;
    assign rsp_hit  = (rsp_resp != 2'd0) && alloc[rsp_tag] && !responded[rsp_tag];
    assign rsp_spur = (rsp_resp != 2'd0) && !rsp_hit;

    always_comb begin
        state_next    = S_IDLE;
        req_cmd_next  = '0;
        req_data_next = '0;
        req_tag_next  = '0;
        case (state)
            S_IDLE, S_OP2: begin
                if (accept) begin
                    state_next    = S_OP1;
                    req_cmd_next  = in_cmd;
                    req_data_next = in_op1;
                    req_tag_next  = free_tag;
                end
            end
            S_OP1: begin
                state_next    = S_OP2;
                req_data_next = op2_q;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef CALC2_ISSUE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] timer [NTAGS];
    logic [NTAGS-1:0] running;
    logic             to_fire;
    logic [TAG_W-1:0] to_tag;

    // A real response always wins the single push slot; an expired timer simply waits.
    always_comb begin
        to_fire = 1'b0;
        to_tag  = '0;
        for (int i = NTAGS-1; i >= 0; i--) begin
            if (!rsp_hit && running[i] && alloc[i] && !responded[i] &&
                timer[i] >= TMR_W'(TIMEOUT_CYC - 1)) begin
                to_fire = 1'b1;
                to_tag  = TAG_W'(i);
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            running <= '0;
            for (int i = 0; i < NTAGS; i++)
                timer[i] <= '0;
        end else begin
            for (int i = 0; i < NTAGS; i++)
                if (running[i] && !responded[i] && timer[i] < TMR_W'(TIMEOUT_CYC - 1))
                    timer[i] <= timer[i] + 1'b1;
            if (state == S_OP2) begin
                running[cur_tag] <= 1'b1;
                timer[cur_tag]   <= TMR_W'(1);
            end
            if (accept)
                running[free_tag] <= 1'b0;
        end
    end
`endif

    always_comb begin
        push           = rsp_hit;
        push_data      = '0;
        push_data.resp = rsp_resp;
        push_data.data = rsp_data;
        push_data.tag  = rsp_tag;
        push_data.cmd  = cmd_mem[rsp_tag];
`ifdef CALC2_ISSUE_TIMEOUT_EN
        if (to_fire) begin
            push           = 1'b1;
            push_data.resp = RESP_INVALID;
            push_data.data = '0;
            push_data.tag  = to_tag;
            push_data.cmd  = cmd_mem[to_tag];
        end
`endif
    end

    // Tags return to the pool only when their completion is consumed.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state        <= S_IDLE;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            req_tag_out  <= '0;
            alloc        <= '0;
            responded    <= '0;
            op2_q        <= '0;
            cur_tag      <= '0;
            spurious_err <= 1'b0;
        end else begin
            state        <= state_next;
            req_cmd_out  <= req_cmd_next;
            req_data_out <= req_data_next;
            req_tag_out  <= req_tag_next;
            if (accept) begin
                alloc[free_tag]     <= 1'b1;
                responded[free_tag] <= 1'b0;
                cmd_mem[free_tag]   <= in_cmd;
                op2_q               <= in_op2;
                cur_tag             <= free_tag;
            end
            if (pop)
                alloc[head.tag] <= 1'b0;
            if (rsp_hit)
                responded[rsp_tag] <= 1'b1;
`ifdef CALC2_ISSUE_TIMEOUT_EN
            if (to_fire)
                responded[to_tag] <= 1'b1;
`endif
            if (rsp_spur)
                spurious_err <= 1'b1;
        end
    end

    calc2_cpl_fifo #(.DEPTH_LOG2(TAG_W)) u_cpl_fifo (
        .clk       (c_clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .valid     (fifo_valid),
        .head      (head)
    );

    assign cpl_valid   = fifo_valid;
    assign cpl_resp    = head.resp;
    assign cpl_data    = head.data;
    assign cpl_tag     = head.tag;
    assign cpl_cmd     = head.cmd;
    assign outstanding = count_ones(alloc);

endmodule

// File: tb/tb_calc2_port_issuer.sv
// Self-checking bench for calc2_port_issuer: vector table, directed corner sequences, random run against a queue model.
// Build with CALC2_ISSUE_TIMEOUT_EN to exercise the watchdog path instead of the long-hold sequences.
module tb_calc2_port_issuer;
    import calc2_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TW = 2;
    localparam int NT = 4;

    logic          c_clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_cmd = '0;
    logic [DW-1:0] in_op1 = '0;
    logic [DW-1:0] in_op2 = '0;
    logic [CW-1:0] req_cmd_out;
    logic [DW-1:0] req_data_out;
    logic [TW-1:0] req_tag_out;
    logic [1:0]    rsp_resp = '0;
    logic [DW-1:0] rsp_data = '0;
    logic [TW-1:0] rsp_tag = '0;
    logic          cpl_valid;
    logic          cpl_ready = 1'b0;
    logic [1:0]    cpl_resp;
    logic [DW-1:0] cpl_data;
    logic [TW-1:0] cpl_tag;
    logic [CW-1:0] cpl_cmd;
    logic [TW:0]   outstanding;
    logic          spurious_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 c_clk = ~c_clk;

    calc2_port_issuer #(
        .DATA_W(DW), .CMD_W(CW), .TAG_W(TW)
`ifdef CALC2_ISSUE_TIMEOUT_EN
        , .TIMEOUT_CYC(8)
`endif
    ) dut (
        .c_clk(c_clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_resp(cpl_resp), .cpl_data(cpl_data),
        .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd), .outstanding(outstanding), .spurious_err(spurious_err)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check_bus(input string name, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [TW-1:0] t);
        check_output({name, "_cmd"}, req_cmd_out, c);
        check_output({name, "_data"}, req_data_out, d);
        check_output({name, "_tag"}, req_tag_out, t);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        rsp_resp = '0;
        cpl_ready = 1'b0;
        tick();
        tick();
        check_output("rst_in_ready", in_ready, 0);
        check_bus("rst_bus", 0, 0, 0);
        check_output("rst_cpl_valid", cpl_valid, 0);
        check_output("rst_cpl_data", cpl_data, 0);
        check_output("rst_outstanding", outstanding, 0);
        check_output("rst_spurious", spurious_err, 0);
        reset = 1'b0;
        #1;
        check_output("rst_release_ready", in_ready, 1);
    endtask

    // Waits (bounded) for in_ready, offers one op, returns the tag seen on the OP1 beat.
    task automatic issue_op(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output logic [TW-1:0] tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_output("issue_ready", in_ready, 1);
        in_valid = 1'b1;
        in_cmd = c;
        in_op1 = a;
        in_op2 = b;
        tick();
        in_valid = 1'b0;
        check_output("op1_cmd", req_cmd_out, c);
        check_output("op1_data", req_data_out, a);
        tag = req_tag_out;
    endtask

    task automatic send_rsp(input logic [1:0] r, input logic [DW-1:0] d, input logic [TW-1:0] t);
        rsp_resp = r;
        rsp_data = d;
        rsp_tag = t;
        tick();
        rsp_resp = '0;
    endtask

    typedef struct {
        logic [CW-1:0] cmd;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
        logic [TW-1:0] exp_tag;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_data;
        logic [CW-1:0] exp_cmd;
    } vec_t;

    vec_t vecs[6];

    // Random-phase reference model: tag pool, completion queue and a queue of bus beats.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } beat_t;

    logic          m_alloc [NT];
    logic          m_done  [NT];
    logic [CW-1:0] m_cmd   [NT];
    cpl_t          m_q[$];
    beat_t         bus_q[$];
    logic          m_spur;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [TW-1:0] tag;
        logic [CW-1:0] cmds [NT];

        vecs[0] = '{4'd1, 32'd5, 32'd7, 2'd1, 32'd12, 2'd0, 2'd1, 32'd12, 4'd1};
        vecs[1] = '{4'd2, 32'd3, 32'd10, 2'd2, 32'hFFFF_FFF9, 2'd0, 2'd2, 32'hFFFF_FFF9, 4'd2};
        vecs[2] = '{4'd5, 32'd1, 32'd4, 2'd1, 32'd16, 2'd0, 2'd1, 32'd16, 4'd5};
        vecs[3] = '{4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1, 2'd0, 2'd1, 32'd1, 4'd6};
        vecs[4] = '{4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 2'd3, 32'd0, 2'd0, 2'd3, 32'd0, 4'd0};
        vecs[5] = '{4'd15, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 2'd3, 32'h55, 2'd0, 2'd3, 32'h55, 4'd15};

        apply_reset();

        foreach (vecs[i]) begin
            issue_op(vecs[i].cmd, vecs[i].op1, vecs[i].op2, tag);
            check_output("vec_tag", tag, vecs[i].exp_tag);
            tick();
            check_bus("vec_op2", 0, vecs[i].op2, 0);
            check_output("vec_op2_ready", in_ready, 1);
            send_rsp(vecs[i].resp, vecs[i].rdata, tag);
            check_bus("vec_idle", 0, 0, 0);
            check_output("vec_cpl_valid", cpl_valid, 1);
            check_output("vec_cpl_resp", cpl_resp, vecs[i].exp_resp);
            check_output("vec_cpl_data", cpl_data, vecs[i].exp_data);
            check_output("vec_cpl_tag", cpl_tag, vecs[i].exp_tag);
            check_output("vec_cpl_cmd", cpl_cmd, vecs[i].exp_cmd);
            check_output("vec_outstanding", outstanding, 1);
            cpl_ready = 1'b1;
            tick();
            cpl_ready = 1'b0;
            check_output("vec_popped", cpl_valid, 0);
            check_output("vec_released", outstanding, 0);
        end

`ifndef CALC2_ISSUE_TIMEOUT_EN
        // Pool exhaustion, out-of-order responses, pop without same-cycle reuse.
        cmds = '{4'd1, 4'd2, 4'd5, 4'd6};
        for (int i = 0; i < NT; i++) begin
            issue_op(cmds[i], 32'(i * 3), 32'(i * 5), tag);
            check_output("pool_tag", tag, i);
        end
        check_output("pool_op1_ready", in_ready, 0);
        tick();
        check_output("pool_full_ready", in_ready, 0);
        check_output("pool_outstanding", outstanding, 4);
        tick();
        check_bus("pool_idle", 0, 0, 0);
        check_output("pool_idle_ready", in_ready, 0);
        begin
            logic [TW-1:0] order [NT];
            order = '{2'd2, 2'd0, 2'd3, 2'd1};
            for (int i = 0; i < NT; i++)
                send_rsp(2'd1, 32'(100 + order[i]), order[i]);
            check_output("ooo_no_spurious", spurious_err, 0);
            check_output("ooo_head_tag", cpl_tag, 2);
            check_output("ooo_head_data", cpl_data, 102);
            check_output("ooo_head_cmd", cpl_cmd, cmds[2]);
            cpl_ready = 1'b1;
            #1;
            check_output("pop_no_bypass", in_ready, 0);
            tick();
            cpl_ready = 1'b0;
            check_output("pop_ready_next", in_ready, 1);
            check_output("pop_outstanding", outstanding, 3);
            issue_op(4'd2, 32'd9, 32'd8, tag);
            check_output("reuse_tag", tag, 2);
            cpl_ready = 1'b1;
            for (int i = 1; i < NT; i++) begin
                check_output("ooo_valid", cpl_valid, 1);
                check_output("ooo_tag", cpl_tag, order[i]);
                check_output("ooo_data", cpl_data, 32'(100 + order[i]));
                check_output("ooo_cmd", cpl_cmd, cmds[order[i]]);
                tick();
            end
            cpl_ready = 1'b0;
            check_output("ooo_drained", cpl_valid, 0);
            check_output("ooo_left", outstanding, 1);
            send_rsp(2'd1, 32'd1, 2'd2);
            check_output("reuse_cpl_cmd", cpl_cmd, 2);
            cpl_ready = 1'b1;
            tick();
            cpl_ready = 1'b0;
            check_output("reuse_outstanding", outstanding, 0);
        end
`endif

        // Spurious response with nothing outstanding.
        apply_reset();
        send_rsp(2'd1, 32'd77, 2'd3);
        check_output("spur_no_cpl", cpl_valid, 0);
        check_output("spur_flag", spurious_err, 1);
        tick();
        tick();
        check_output("spur_sticky", spurious_err, 1);

        // Reset during the OP2 beat.
        issue_op(4'd1, 32'd11, 32'd22, tag);
        tick();
        check_bus("mid_op2", 0, 22, 0);
        reset = 1'b1;
        #1;
        check_output("mid_rst_ready", in_ready, 0);
        tick();
        check_bus("mid_rst_bus", 0, 0, 0);
        check_output("mid_rst_outstanding", outstanding, 0);
        check_output("mid_rst_cpl", cpl_valid, 0);
        check_output("mid_rst_spur", spurious_err, 0);
        reset = 1'b0;
        #1;
        issue_op(4'd2, 32'd1, 32'd2, tag);
        check_output("mid_rst_tag", tag, 0);
        tick();
        tick();

`ifdef CALC2_ISSUE_TIMEOUT_EN
        apply_reset();
        issue_op(4'd1, 32'd3, 32'd4, tag);
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_output("to_wait", cpl_valid, 0);
        end
        tick();
        check_output("to_valid", cpl_valid, 1);
        check_output("to_resp", cpl_resp, 3);
        check_output("to_data", cpl_data, 0);
        check_output("to_tag", cpl_tag, 0);
        check_output("to_cmd", cpl_cmd, 1);
        send_rsp(2'd1, 32'd7, 2'd0);
        check_output("to_late_spur", spurious_err, 1);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        check_output("to_released", outstanding, 0);
`else
        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < NT; i++) begin
            m_alloc[i] = 1'b0;
            m_done[i] = 1'b0;
            m_cmd[i] = '0;
        end
        m_q.delete();
        bus_q.delete();
        m_spur = 1'b0;
        begin
            beat_t cur;
            cur = '0;
            for (int cyc = 0; cyc < 500; cyc++) begin
                int n_alloc, pend[$], r;
                logic any_free, exp_ready, acc, pop, hit;
                logic [TW-1:0] atag, ptag;
                cpl_t e;

                n_alloc = 0;
                any_free = 1'b0;
                atag = '0;
                for (int t = NT - 1; t >= 0; t--) begin
                    if (m_alloc[t]) n_alloc++;
                    else begin
                        any_free = 1'b1;
                        atag = TW'(t);
                    end
                    if (m_alloc[t] && !m_done[t]) pend.push_back(t);
                end
                exp_ready = any_free && (bus_q.size() == 0);

                check_bus("rnd_bus", cur.c, cur.d, cur.t);
                check_output("rnd_in_ready", in_ready, exp_ready);
                check_output("rnd_cpl_valid", cpl_valid, m_q.size() != 0);
                if (m_q.size() != 0)
                    check_output("rnd_cpl_head", {cpl_resp, cpl_data, cpl_tag, cpl_cmd}, m_q[0]);
                check_output("rnd_outstanding", outstanding, n_alloc);
                check_output("rnd_spurious", spurious_err, m_spur);

                in_valid = ($urandom_range(0, 9) < 7);
                in_cmd = CW'($urandom_range(0, 15));
                in_op1 = $urandom;
                in_op2 = $urandom;
                cpl_ready = ($urandom_range(0, 1) == 1);
                r = $urandom_range(0, 9);
                rsp_resp = '0;
                if (r >= 5) begin
                    rsp_resp = 2'($urandom_range(1, 3));
                    rsp_data = $urandom;
                    if (r < 9 && pend.size() != 0)
                        rsp_tag = TW'(pend[$urandom_range(0, pend.size() - 1)]);
                    else
                        rsp_tag = TW'($urandom_range(0, NT - 1));
                end

                acc = in_valid && exp_ready;
                pop = cpl_ready && (m_q.size() != 0);
                ptag = (m_q.size() != 0) ? m_q[0].tag : '0;
                hit = (rsp_resp != 0) && m_alloc[rsp_tag] && !m_done[rsp_tag];
                if (rsp_resp != 0 && !hit) m_spur = 1'b1;
                if (pop) begin
                    m_alloc[ptag] = 1'b0;
                    void'(m_q.pop_front());
                end
                if (hit) begin
                    e.resp = rsp_resp;
                    e.data = rsp_data;
                    e.tag = rsp_tag;
                    e.cmd = m_cmd[rsp_tag];
                    m_q.push_back(e);
                    m_done[rsp_tag] = 1'b1;
                end
                if (acc) begin
                    m_alloc[atag] = 1'b1;
                    m_done[atag] = 1'b0;
                    m_cmd[atag] = in_cmd;
                    bus_q.push_back('{in_cmd, in_op1, atag});
                    bus_q.push_back('{4'd0, in_op2, 2'd0});
                end
                tick();
                cur = (bus_q.size() != 0) ? bus_q.pop_front() : '0;
            end
        end
        in_valid = 1'b0;
        rsp_resp = '0;
        cpl_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
